// File: rtl/mem_port_arb.sv
// Shares one memory port between instruction fetch (I) and load/store (D), one transaction in flight.
// Build option MEM_ARB_RR_EN: round-robin on conflicts instead of D-priority with an I starvation limit.
module mem_port_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            err_spurious,
    output logic [1:0]      dbg_state
);

    // Handshakes: x_req is held until the one-cycle x_gnt; m_req is held with stable m_* until m_gnt;
    // x_rvalid / m_rvalid are single-cycle pulses with no back-pressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                win_i, win_d, i_first, accept;
    logic                owner_i, we_q;
    logic [DW/8-1:0]     be_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       wdata_q;

`ifdef MEM_ARB_RR_EN
    logic last_d;
    assign i_first = last_d;

    always_ff @(posedge clk) begin
        if (rst)         last_d <= 1'b1;
        else if (accept) last_d <= win_d;
    end
`else
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;
    assign i_first = (starve_cnt == SMAX);

    // Counts consecutive D wins that left I waiting; saturates so I wins the next conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (accept) begin
            if (win_d && i_req) begin
                if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end
`endif

    assign win_i  = i_req && (!d_req || i_first);
    assign win_d  = d_req && !win_i;
    assign accept = (state == IDLE) && (i_req || d_req);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nxt = ISSUE;
            ISSUE:   if (m_gnt)          state_nxt = RESP;
            RESP:    if (m_rvalid)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_i <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            owner_i <= win_i;
            if (win_i) begin
                we_q    <= 1'b0;
                be_q    <= '1;
                addr_q  <= i_addr;
                wdata_q <= '0;
            end else begin
                we_q    <= d_we;
                be_q    <= d_be;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                            err_spurious <= 1'b0;
        else if (m_rvalid && state != RESP) err_spurious <= 1'b1;
    end

    // Handshake outputs are held low while rst is asserted so an abandoned transaction never completes.
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        m_req    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    i_gnt = win_i;
                    d_gnt = win_d;
                end
                ISSUE: m_req = 1'b1;
                RESP: begin
                    if (m_rvalid) begin
                        if (owner_i) begin
                            i_rvalid = 1'b1;
                            i_rdata  = we_q ? '0 : m_rdata;
                        end else begin
                            d_rvalid = 1'b1;
                            d_rdata  = we_q ? '0 : m_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_we      = we_q;
    assign m_be      = be_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign dbg_state = state;

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates one shared memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Lets the core run with a single unified memory, as on a multi-cycle or FPGA build.
- One outstanding transaction at a time.
- Fixed D-priority arbitration with an anti-starvation limit for I; memory side uses a req/gnt + rvalid protocol with variable latency.

Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width
- STARVE_MAX, 4, consecutive D wins allowed while I waits; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch request; held stable until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch request accepted (1-cycle pulse)
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DW  fetch data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  byte enables (store)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data / store ack (1-cycle pulse)
- d_rdata  out  DW  load data; 0 for store ack
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_be  out  DW/8  memory byte enables
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_gnt  in  1  memory accepted request
- m_rvalid  in  1  memory response (reads and writes)
- m_rdata  in  DW  memory read data
- err_spurious  out  1  sticky: m_rvalid arrived outside RESP

Behaviour:
- Reset: all outputs 0, state IDLE, starve_cnt 0, owner cleared, err_spurious 0. Reset mid-transaction abandons it; no x_rvalid is produced for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, arbitration (combinational):
  - Only one of i_req/d_req high: that requester wins.
  - Both high: D wins unless starve_cnt == STARVE_MAX, in which case I wins.
- IDLE, on a winner:
  - Winner's x_gnt = 1 the same cycle.
  - Latch addr, we, be, wdata (I: we=0, be=all-ones, wdata=0) and the owner.
  - Next state ISSUE.
- starve_cnt update:
  - Increments, saturating at STARVE_MAX, when D wins while i_req = 1.
  - Clears when I wins, or when D wins with i_req = 0.
- ISSUE:
  - m_req = 1; m_* driven from latched registers, stable until m_gnt.
  - m_gnt = 1 → RESP.
- RESP:
  - m_req = 0.
  - m_rvalid = 1 → owner's x_rvalid = 1 the same cycle.
  - Owner's x_rdata = m_rdata for reads, 0 for stores.
  - Next state IDLE.
- m_gnt and m_rvalid in the same ISSUE cycle are not supported; the memory responds at the earliest one cycle after m_gnt.
- Minimum occupancy per transaction: 3 cycles (IDLE accept, ISSUE, RESP). The next grant is possible in the cycle after RESP.
- Requests arriving in ISSUE/RESP are ignored until IDLE; requesters hold them.
- x_rvalid/x_rdata of the non-owner are 0 at all times.
- m_rvalid in IDLE or ISSUE: ignored and err_spurious set. err_spurious is cleared only by rst.
- Address arithmetic: none; addresses pass unchanged, width AW.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - On conflict, arbitration is round-robin: the requester that did not win the last grant wins.
  - starve_cnt and STARVE_MAX are unused; the last-winner flag resets to D, so I wins the first conflict.
- MEM_ARB_RR_EN undefined: fixed D-priority with the starvation limit as specified.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; m_gnt in ISSUE; m_rvalid two cycles later with m_rdata=0x00000013 → i_gnt cycle 0, m_req cycle 1 with m_addr=0x100, m_we=0, m_be=0xF; i_rvalid=1, i_rdata=0x13 on the m_rvalid cycle; d_rvalid stays 0.
- Store ack: d_req=1, d_we=1, d_be=0x3, d_addr=0x2004, d_wdata=0xDEADBEEF → m_we=1, m_be=0x3, m_addr=0x2004, m_wdata=0xDEADBEEF; d_rvalid=1, d_rdata=0 on m_rvalid.
- Starvation: i_req and d_req held high continuously, each transaction completes, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I. With MEM_ARB_RR_EN → I,D,I,D.
- m_gnt stall: m_gnt held low 5 cycles in ISSUE while d_addr/d_wdata inputs change after d_gnt → m_addr/m_wdata stay at latched values; RESP entered only after m_gnt.
- Reset mid-op: rst=1 for one cycle in RESP, then m_rvalid=1 → no i_rvalid/d_rvalid; err_spurious=1; state IDLE; new i_req granted normally.
- Back-to-back loads: d_req held for 2 loads to 0x10 and 0x14, memory latency 1 → d_gnt pulses 3 cycles apart; rdata routed in order.
